fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end.
//   XLEN          : instruction/data word width
//   ECALL         : encoding that halts the fetch unit when accepted by decode
//   fetch_state_t : fetch controller FSM states
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] ECALL = 32'h00000073;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO buffering {pc, instr} pairs between memory return and decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (caller guarantees not full unless also popping)
//   i_data     : entry to write
//   i_pop      : discard head (caller guarantees not empty)
//   i_flush    : drop all entries; overrides push/pop
//   o_data     : head entry
//   o_valid    : FIFO not empty
//   o_count    : number of stored entries (0..2)
module fetch_fifo #(
    parameter int unsigned WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (i_pop) begin
                r_rd <= ~r_rd;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues word addresses to instr_fetch, buffers
// the 1-cycle-latency returns in a 2-entry FIFO and hands them to decode with
// a valid/ready handshake. Supports redirects and halts on ECALL or end of
// instruction memory.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : level, leaves IDLE
//   imem_addr      : byte address presented to instruction memory
//   imem_data      : memory read data, valid the cycle after imem_addr
//   instr_valid    : instr/instr_pc hold a fetched instruction
//   instr_ready    : decode accepts the head instruction
//   instr, instr_pc: head instruction and its byte address
//   redirect_valid : one-cycle taken branch/jump pulse
//   redirect_pc    : redirect target (low two bits ignored)
//   halted         : FSM in HALT
//   stall_cnt      : saturating count of valid && !ready cycles
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned           ADDR_W     = 8,
    parameter int unsigned           IMEM_WORDS = 48,
    parameter logic [ADDR_W-1:0]     RESET_PC   = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [XLEN-1:0]   instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned PC_LIMIT = IMEM_WORDS * 4;

    fetch_state_t      r_state, w_next_state;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_flight_pc;
    logic [15:0]       r_stall_cnt;

    logic                     w_issue;
    logic                     w_flush;
    logic                     w_push;
    logic                     w_xfer;
    logic                     w_fifo_valid;
    logic [1:0]               w_count;
    logic [ADDR_W+XLEN-1:0]   w_head;
    logic [2:0]               w_occ;
    logic                     w_pc_end;
    logic                     w_drained;
    logic [ADDR_W-1:0]        w_target;

    assign w_xfer    = w_fifo_valid && instr_ready;
    assign w_occ     = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_pc_end  = (32'(r_pc) >= PC_LIMIT);
    assign w_target  = {redirect_pc[ADDR_W-1:2], 2'b00};
    // Nothing left to deliver after this cycle: no word returning and the
    // FIFO is empty or its last entry is leaving now.
    assign w_drained = !r_inflight &&
                       ((w_count == 2'd0) || ((w_count == 2'd1) && w_xfer));
    // A returning word is kept only if its issue is still marked in flight.
    assign w_push    = r_inflight && !w_flush;

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_issue      = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    w_flush   = 1'b1;
                    w_pc_next = w_target;
                end else if (w_xfer && (w_head[XLEN-1:0] == ECALL)) begin
                    w_flush      = 1'b1;
                    w_next_state = ST_HALT;
                end else if (w_pc_end && w_drained) begin
                    w_flush      = 1'b1;
                    w_next_state = ST_HALT;
                end else if (!w_pc_end && ((w_occ < 3'd2) || w_xfer)) begin
                    w_issue   = 1'b1;
                    w_pc_next = r_pc + ADDR_W'(4);
                end
            end
            ST_HALT: begin
                w_flush = 1'b1;
                if (redirect_valid) begin
                    w_next_state = ST_RUN;
                    w_pc_next    = w_target;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_flush      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_inflight  <= 1'b0;
            r_flight_pc <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_pc_next;
            r_inflight <= w_issue;
            if (w_issue) r_flight_pc <= r_pc;
            if (w_fifo_valid && !instr_ready && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    fetch_fifo #(
        .WIDTH(ADDR_W + XLEN)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_push),
        .i_data ({r_flight_pc, imem_data}),
        .i_pop  (w_xfer),
        .i_flush(w_flush),
        .o_data (w_head),
        .o_valid(w_fifo_valid),
        .o_count(w_count)
    );

    assign imem_addr   = r_pc;
    assign instr_valid = w_fifo_valid;
    assign instr       = w_head[XLEN-1:0];
    assign instr_pc    = w_head[ADDR_W+XLEN-1:XLEN];
    assign halted      = (r_state == ST_HALT);
    assign stall_cnt   = r_stall_cnt;

endmodule
